// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
//   Sequencing controller for an iterative SHA-256 compression datapath.
//   Accepts one 512-bit block at a time, runs an INIT cycle, ROUNDS round
//   cycles and a FINAL digest-update cycle, and pulses digest_valid in DONE
//   when the block was the last one of its message.  It also owns the
//   working-variable registers (a..h) and the digest registers (H0..H7),
//   which load whatever the external datapath presents on their strobes.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   block_valid/block_ready  block handshake; block_first/block_last sampled
//                            on accept
//   round_idx                current round t (W/K lookup index)
//   init_round, partial_rounds, init_digest, update_digest, first_block
//                            control strobes to the variable-update datapath
//   a_new..h_new, update_AH  next working variables and their load strobe
//   H0_new..H7_new, update_H next digest words and their load strobe
//   a_reg..h_reg             working-variable registers
//   H0_reg..H7_reg, digest   digest registers, digest = {H0_reg..H7_reg}
//   digest_valid             one-cycle pulse when the digest is final
//   busy                     high in every state except IDLE
// ---------------------------------------------------------------------------

// Protocol checker: control strobes stay mutually exclusive and consistent.
module sha256_round_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic init_round,
    input logic partial_rounds,
    input logic init_digest,
    input logic update_digest,
    input logic first_block,
    input logic block_ready,
    input logic busy,
    input logic digest_valid
);

    a_round_excl : assert property (@(posedge clk) disable iff (rst)
        !(init_round && partial_rounds));

    a_digest_excl : assert property (@(posedge clk) disable iff (rst)
        !(init_digest && update_digest));

    a_first_in_init : assert property (@(posedge clk) disable iff (rst)
        !(first_block && !init_round));

    a_ready_busy_excl : assert property (@(posedge clk) disable iff (rst)
        !(block_ready && busy));

    a_valid_while_busy : assert property (@(posedge clk) disable iff (rst)
        !(digest_valid && !busy));

endmodule

module sha256_round_ctrl #(
    parameter int ROUNDS = 64      // compression rounds per block, 2..64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic         block_first,
    input  logic         block_last,
    output logic [5:0]   round_idx,
    output logic         init_round,
    output logic         partial_rounds,
    output logic         init_digest,
    output logic         update_digest,
    output logic         first_block,
    input  logic [31:0]  a_new,
    input  logic [31:0]  b_new,
    input  logic [31:0]  c_new,
    input  logic [31:0]  d_new,
    input  logic [31:0]  e_new,
    input  logic [31:0]  f_new,
    input  logic [31:0]  g_new,
    input  logic [31:0]  h_new,
    input  logic         update_AH,
    input  logic [31:0]  H0_new,
    input  logic [31:0]  H1_new,
    input  logic [31:0]  H2_new,
    input  logic [31:0]  H3_new,
    input  logic [31:0]  H4_new,
    input  logic [31:0]  H5_new,
    input  logic [31:0]  H6_new,
    input  logic [31:0]  H7_new,
    input  logic         update_H,
    output logic [31:0]  a_reg,
    output logic [31:0]  b_reg,
    output logic [31:0]  c_reg,
    output logic [31:0]  d_reg,
    output logic [31:0]  e_reg,
    output logic [31:0]  f_reg,
    output logic [31:0]  g_reg,
    output logic [31:0]  h_reg,
    output logic [31:0]  H0_reg,
    output logic [31:0]  H1_reg,
    output logic [31:0]  H2_reg,
    output logic [31:0]  H3_reg,
    output logic [31:0]  H4_reg,
    output logic [31:0]  H5_reg,
    output logic [31:0]  H6_reg,
    output logic [31:0]  H7_reg,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          accept_s;
    logic          round_last_s;
    logic [5:0]    round_idx_r;
    logic [5:0]    round_idx_next_s;
    logic          first_lat_r;
    logic          last_lat_r;

    // Control outputs are registered from the next state so every output
    // is a flop while still lining up with the state it belongs to.
    logic          block_ready_s;
    logic          busy_s;
    logic          init_round_s;
    logic          partial_rounds_s;
    logic          init_digest_s;
    logic          update_digest_s;
    logic          first_block_s;
    logic          digest_valid_s;
    logic          block_ready_r;
    logic          busy_r;
    logic          init_round_r;
    logic          partial_rounds_r;
    logic          init_digest_r;
    logic          update_digest_r;
    logic          first_block_r;
    logic          digest_valid_r;

    logic [255:0]  ah_r;
    logic [255:0]  hv_r;

    // Next-state and round-counter logic.
    always_comb begin
        state_next_s     = state_r;
        accept_s         = 1'b0;
        round_last_s     = (round_idx_r == LAST_IDX);
        round_idx_next_s = 6'd0;
        case (state_r)
            ST_IDLE: begin
                if (block_valid && block_ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_INIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_next_s = ST_ROUND;
            end
            ST_ROUND: begin
                if (round_last_s) begin
                    state_next_s     = ST_FINAL;
                    round_idx_next_s = 6'd0;
                end else begin
                    state_next_s     = ST_ROUND;
                    round_idx_next_s = round_idx_r + 6'd1;
                end
            end
            ST_FINAL: begin
                if (last_lat_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode of the state being entered.
    always_comb begin
        block_ready_s    = 1'b0;
        busy_s           = 1'b0;
        init_round_s     = 1'b0;
        partial_rounds_s = 1'b0;
        init_digest_s    = 1'b0;
        update_digest_s  = 1'b0;
        first_block_s    = 1'b0;
        digest_valid_s   = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                block_ready_s = 1'b1;
            end
            ST_INIT: begin
                busy_s        = 1'b1;
                init_round_s  = 1'b1;
                init_digest_s = 1'b1;
                // INIT is only entered on accept, so the flag is taken
                // straight from the input that is being latched this edge.
                first_block_s = accept_s ? block_first : first_lat_r;
            end
            ST_ROUND: begin
                busy_s           = 1'b1;
                partial_rounds_s = 1'b1;
            end
            ST_FINAL: begin
                busy_s          = 1'b1;
                update_digest_s = 1'b1;
            end
            ST_DONE: begin
                busy_s         = 1'b1;
                digest_valid_s = 1'b1;
            end
            default: begin
                block_ready_s = 1'b0;
            end
        endcase
    end

    // State and round-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            round_idx_r <= 6'd0;
        end else begin
            state_r     <= state_next_s;
            round_idx_r <= round_idx_next_s;
        end
    end

    // Block attributes captured at the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_lat_r <= 1'b0;
            last_lat_r  <= 1'b0;
        end else if (accept_s) begin
            first_lat_r <= block_first;
            last_lat_r  <= block_last;
        end
    end

    // Registered control outputs; block_ready stays low while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            block_ready_r    <= 1'b0;
            busy_r           <= 1'b0;
            init_round_r     <= 1'b0;
            partial_rounds_r <= 1'b0;
            init_digest_r    <= 1'b0;
            update_digest_r  <= 1'b0;
            first_block_r    <= 1'b0;
            digest_valid_r   <= 1'b0;
        end else begin
            block_ready_r    <= block_ready_s;
            busy_r           <= busy_s;
            init_round_r     <= init_round_s;
            partial_rounds_r <= partial_rounds_s;
            init_digest_r    <= init_digest_s;
            update_digest_r  <= update_digest_s;
            first_block_r    <= first_block_s;
            digest_valid_r   <= digest_valid_s;
        end
    end

    // Working variables a..h: load on strobe in any state (no stall logic).
    always_ff @(posedge clk) begin
        if (rst) begin
            ah_r <= 256'd0;
        end else if (update_AH) begin
            ah_r <= {a_new, b_new, c_new, d_new, e_new, f_new, g_new, h_new};
        end
    end

    // Digest words H0..H7: load on strobe in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hv_r <= 256'd0;
        end else if (update_H) begin
            hv_r <= {H0_new, H1_new, H2_new, H3_new, H4_new, H5_new, H6_new, H7_new};
        end
    end

    assign block_ready    = block_ready_r;
    assign busy           = busy_r;
    assign init_round     = init_round_r;
    assign partial_rounds = partial_rounds_r;
    assign init_digest    = init_digest_r;
    assign update_digest  = update_digest_r;
    assign first_block    = first_block_r;
    assign digest_valid   = digest_valid_r;
    assign round_idx      = round_idx_r;

    assign {a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg} = ah_r;
    assign {H0_reg, H1_reg, H2_reg, H3_reg, H4_reg, H5_reg, H6_reg, H7_reg} = hv_r;
    assign digest = hv_r;

    sha256_round_ctrl_chk u_chk (
        .clk            (clk),
        .rst            (rst),
        .init_round     (init_round_r),
        .partial_rounds (partial_rounds_r),
        .init_digest    (init_digest_r),
        .update_digest  (update_digest_r),
        .first_block    (first_block_r),
        .block_ready    (block_ready_r),
        .busy           (busy_r),
        .digest_valid   (digest_valid_r)
    );

endmodule
